// File: rtl/dac_pkg.sv
// Shared constants, FSM encoding and frame builder for the DAC channel scheduler.
package dac_pkg;

   localparam int         FRAME_W    = 32;
   localparam logic [3:0] CMD_WR_UPD = 4'b0011;
   localparam logic [3:0] ADDR_A     = 4'h0;
   localparam logic [3:0] ADDR_B     = 4'h1;
   localparam logic [3:0] ADDR_C     = 4'h2;
   localparam logic [3:0] ADDR_D     = 4'h3;
   localparam logic [3:0] ADDR_ALL   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SHIFT,
      ST_GAP
   } dac_state_e;

   // Undefined addresses pass through untouched; the DAC decides what to do with them.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] addr, input logic [11:0] data);
      return {8'h00, CMD_WR_UPD, addr, data, 4'h0};
   endfunction

endpackage

// File: rtl/dac_channel_scheduler_if.sv
// Requester-side handshake plus DAC pin bundle for the channel scheduler.
interface dac_channel_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [4*NUM_REQ-1:0]  req_addr;
   logic [12*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  done;
   logic                  dac_cs_n;
   logic                  dac_sck;
   logic                  dac_mosi;
   logic                  dac_clr_n;

   modport master (
      output req, req_addr, req_data,
      input  grant, busy, done, dac_cs_n, dac_sck, dac_mosi, dac_clr_n
   );

   modport slave (
      input  req, req_addr, req_data,
      output grant, busy, done, dac_cs_n, dac_sck, dac_mosi, dac_clr_n
   );
endinterface

// File: rtl/dac_spi_shifter.sv
// Mode-0 SPI serializer: SCK divider, 32-bit MSB-first shift register and bit counter.
module dac_spi_shifter
   import dac_pkg::*;
#(
   parameter int DIV_HALF = 4
) (
   input  logic               clock_in,
   input  logic               reset_n,
   input  logic               load,
   input  logic [FRAME_W-1:0] frame_in,
   output logic               shifting,
   output logic               last,
   output logic               sck,
   output logic               mosi
);
   localparam int               DIV_W      = $clog2(DIV_HALF + 1);
   localparam int               BIT_W      = $clog2(FRAME_W);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

   logic [FRAME_W-1:0] shift_q;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic               phase_end;

   assign phase_end = shifting && (div_cnt == '0);
   assign last      = phase_end && sck && (bit_cnt == '0);
   assign mosi      = shifting && shift_q[FRAME_W-1];

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         shift_q  <= '0;
         shifting <= 1'b0;
         sck      <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
      end else if (load) begin
         shift_q  <= frame_in;
         shifting <= 1'b1;
         sck      <= 1'b0;
         div_cnt  <= DIV_RELOAD;
         bit_cnt  <= BIT_LAST;
      end else if (phase_end) begin
         div_cnt <= DIV_RELOAD;
         if (!sck) begin
            sck <= 1'b1;
         end else begin
            // Advance data on the falling edge so MOSI only moves while SCK is low.
            sck     <= 1'b0;
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
            if (bit_cnt == '0) shifting <= 1'b0;
            else               bit_cnt  <= bit_cnt - 1'b1;
         end
      end else if (shifting) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler sharing one 4-channel SPI DAC between NUM_REQ requesters.
//   state    | meaning
//   ST_IDLE  | waiting for any req; winner chosen from the rr pointer
//   ST_GRANT | one-cycle grant pulse, frame loaded into the shifter
//   ST_SHIFT | cs_n low, 32 bits clocked out
//   ST_GAP   | cs_n high for GAP_CYC cycles before the next arbitration
module dac_channel_scheduler
   import dac_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DIV_HALF = 4,
   parameter int GAP_CYC  = 8
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   dac_channel_scheduler_if.slave  bus
);
   localparam int               PTR_W      = $clog2(NUM_REQ);
   localparam int               GAP_W      = $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);

   dac_state_e         state;
   dac_state_e         state_nxt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_nxt;
   logic [PTR_W-1:0]   win_sel;
   logic [PTR_W-1:0]   win_q;
   logic [PTR_W-1:0]   cand;
   logic [GAP_W-1:0]   gap_cnt;
   logic               clr_q;
   logic               done_q;
   logic               load;
   logic               shifting;
   logic               last;
   logic [3:0]         addr_arr [NUM_REQ];
   logic [11:0]        data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = bus.req_addr[4*g +: 4];
      assign data_arr[g] = bus.req_data[12*g +: 12];
   end

   // Scan offsets from farthest to nearest so the first asserted req at/after rr_ptr wins.
   always_comb begin
      win_sel = rr_ptr;
      cand    = rr_ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (bus.req[cand]) win_sel = cand;
      end
   end

   assign rr_ptr_nxt = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE:  if (|bus.req) state_nxt = ST_GRANT;
         ST_GRANT: begin
            load      = 1'b1;
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: if (last) state_nxt = ST_GAP;
         ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         win_q   <= '0;
         gap_cnt <= '0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         clr_q  <= 1'b1;
         done_q <= last;
         if (state == ST_IDLE)  win_q  <= win_sel;
         if (state == ST_GRANT) rr_ptr <= rr_ptr_nxt;
         if (last)                                 gap_cnt <= GAP_RELOAD;
         else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end
   end

   dac_spi_shifter #(
      .DIV_HALF (DIV_HALF)
   ) u_shifter (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .load     (load),
      .frame_in (build_frame(addr_arr[win_q], data_arr[win_q])),
      .shifting (shifting),
      .last     (last),
      .sck      (bus.dac_sck),
      .mosi     (bus.dac_mosi)
   );

   assign bus.grant     = (state == ST_GRANT) ? (NUM_REQ'(1) << win_q) : '0;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.dac_cs_n  = !shifting;
   assign bus.dac_clr_n = clr_q;

endmodule
